branch_pred_ctrl: RTL and testbench

BRANCH_PRED_CTRL -- requirements
Module: branch_pred_ctrl

---
 rtl/branch_pred_ctrl_if.sv | 33 +++
 rtl/branch_pred_ctrl.sv | 86 ++++++++
 tb/tb_branch_pred_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/branch_pred_ctrl_if.sv
// Fetch/execute bundle between the pipeline and the branch predictor.
// The slave side is the predictor; the master side is the pipeline.
interface branch_pred_ctrl_if;
    logic [31:0] PCF;
    logic        BtbHitF;
    logic [31:0] BtbTargetF;
    logic        StallD;
    logic        FlushD;
    logic        StallE;
    logic        FlushE;
    logic [31:0] PCE;
    logic [6:0]  OpE;
    logic        BranchE;
    logic [31:0] BrNPC;
    logic [31:0] PredNPCF;
    logic        PredTakenF;
    logic        MispredictE;
    logic [31:0] CorrectPCE;
    logic [31:0] BrCount;
    logic [31:0] MissCount;

    modport slave (
        input  PCF, BtbHitF, BtbTargetF, StallD, FlushD, StallE, FlushE,
               PCE, OpE, BranchE, BrNPC,
        output PredNPCF, PredTakenF, MispredictE, CorrectPCE, BrCount, MissCount
    );

    modport master (
        output PCF, BtbHitF, BtbTargetF, StallD, FlushD, StallE, FlushE,
               PCE, OpE, BranchE, BrNPC,
        input  PredNPCF, PredTakenF, MispredictE, CorrectPCE, BrCount, MissCount
    );
endinterface

// File: rtl/branch_pred_ctrl.sv
// Bimodal (2-bit counter) branch predictor with BTB-gated fetch prediction,
// F->D->E prediction record pipeline, execute-stage resolution and statistics.
module branch_pred_ctrl #(
    parameter int BHT_ENTRY_NUM = 64
) (
    input  logic                clk,
    input  logic                rst,
    branch_pred_ctrl_if.slave   bp
);
    localparam int         IDX_W     = $clog2(BHT_ENTRY_NUM);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic        vld;
        logic        tkn;
        logic [31:0] tgt;
    } pred_rec_t;

    logic [1:0]       r_bht [BHT_ENTRY_NUM];
    pred_rec_t        r_rec_d;
    pred_rec_t        r_rec_e;
    pred_rec_t        w_rec_f;
    logic [31:0]      r_br_cnt;
    logic [31:0]      r_miss_cnt;
    logic [IDX_W-1:0] w_idx_f;
    logic [IDX_W-1:0] w_idx_e;
    logic             w_pred_tkn;
    logic             w_resolve;
    logic             w_mispred;

    assign w_idx_f    = bp.PCF[IDX_W+1:2];
    assign w_idx_e    = bp.PCE[IDX_W+1:2];
    assign w_pred_tkn = bp.BtbHitF & r_bht[w_idx_f][1];

    assign bp.PredTakenF = w_pred_tkn;
    assign bp.PredNPCF   = w_pred_tkn ? bp.BtbTargetF : bp.PCF + 32'd4;

    assign w_rec_f = '{vld: 1'b1, tkn: w_pred_tkn, tgt: bp.PredNPCF};

    assign w_resolve = r_rec_e.vld && (bp.OpE == OP_BRANCH) && !bp.StallE;
    // A correct taken direction still mispredicts if the BTB target was stale.
    assign w_mispred = w_resolve &&
                       ((r_rec_e.tkn != bp.BranchE) ||
                        (r_rec_e.tkn && bp.BranchE && (r_rec_e.tgt != bp.BrNPC)));

    assign bp.MispredictE = w_mispred;
    assign bp.CorrectPCE  = !w_resolve ? 32'd0 :
                            bp.BranchE ? bp.BrNPC : bp.PCE + 32'd4;
    assign bp.BrCount     = r_br_cnt;
    assign bp.MissCount   = r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rec_d <= '0;
            r_rec_e <= '0;
        end else begin
            if (bp.FlushD)       r_rec_d <= '0;
            else if (!bp.StallD) r_rec_d <= w_rec_f;
            if (bp.FlushE)       r_rec_e <= '0;
            else if (!bp.StallE) r_rec_e <= r_rec_d;
        end
    end

    // Fetch reads the registered array, so a same-index update is not bypassed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRY_NUM; i++) r_bht[i] <= 2'b01;
        end else if (w_resolve) begin
            if (bp.BranchE) begin
                if (r_bht[w_idx_e] != 2'b11) r_bht[w_idx_e] <= r_bht[w_idx_e] + 2'b01;
            end else begin
                if (r_bht[w_idx_e] != 2'b00) r_bht[w_idx_e] <= r_bht[w_idx_e] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_cnt   <= '0;
            r_miss_cnt <= '0;
        end else if (w_resolve) begin
            if (r_br_cnt != 32'hFFFF_FFFF) r_br_cnt <= r_br_cnt + 32'd1;
            if (w_mispred && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl: fetch predictions, resolution,
// stall/flush handling and mid-operation reset, with a resolution scoreboard.
module tb_branch_pred_ctrl;
    localparam logic [6:0] BR = 7'b1100011;

    typedef struct {
        logic        mis;
        logic [31:0] cpc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    branch_pred_ctrl_if bp();

    branch_pred_ctrl #(.BHT_ENTRY_NUM(64)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_mispredict"}, {31'd0, bp.MispredictE}, {31'd0, e.mis});
            chk({tag, "_correct_pc"}, bp.CorrectPCE, e.cpc);
        end
    endtask

    task automatic idle_f();
        bp.PCF = 32'h4; bp.BtbHitF = 1'b0; bp.BtbTargetF = 32'h0;
    endtask

    // Fetch pc with a BTB hit, walk it to E, resolve it; called at a negedge.
    task automatic br(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                      input logic pred, input logic tkn, input logic [31:0] act,
                      input logic exp_mis, input logic [31:0] exp_cpc);
        bp.PCF = pc; bp.BtbHitF = 1'b1; bp.BtbTargetF = tgt; bp.OpE = 7'h0;
        #1 chk({tag, "_pred_f"}, {31'd0, bp.PredTakenF}, {31'd0, pred});
        @(negedge clk); idle_f();
        @(negedge clk);
        bp.PCF = pc; bp.BtbHitF = 1'b1;
        bp.PCE = pc; bp.OpE = BR; bp.BranchE = tkn; bp.BrNPC = act;
        sb.push_back('{mis: exp_mis, cpc: exp_cpc});
        #1 chk({tag, "_no_bypass"}, {31'd0, bp.PredTakenF}, {31'd0, pred});
        sb_check(tag);
        @(negedge clk); bp.OpE = 7'h0; idle_f();
    endtask

    initial begin
        bp.PCF = 32'h100; bp.BtbHitF = 1'b0; bp.BtbTargetF = 32'h0;
        bp.StallD = 1'b0; bp.FlushD = 1'b0; bp.StallE = 1'b0; bp.FlushE = 1'b0;
        bp.PCE = 32'h0; bp.OpE = 7'h0; bp.BranchE = 1'b0; bp.BrNPC = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pred",  {31'd0, bp.PredTakenF}, 32'd0);
        chk("rst_npc",   bp.PredNPCF, 32'h104);
        chk("rst_mis",   {31'd0, bp.MispredictE}, 32'd0);
        chk("rst_cpc",   bp.CorrectPCE, 32'd0);
        chk("rst_brcnt", bp.BrCount, 32'd0);
        chk("rst_miss",  bp.MissCount, 32'd0);

        @(negedge clk); rst = 1'b0;
        bp.PCF = 32'h100; bp.BtbHitF = 1'b1; bp.BtbTargetF = 32'h200;
        #1;
        chk("weak_pred", {31'd0, bp.PredTakenF}, 32'd0);
        chk("weak_npc",  bp.PredNPCF, 32'h104);
        @(negedge clk);

        br("first_taken", 32'h100, 32'h200, 1'b0, 1'b1, 32'h200, 1'b1, 32'h200);
        chk("first_brcnt", bp.BrCount, 32'd1);
        chk("first_miss",  bp.MissCount, 32'd1);
        bp.PCF = 32'h100; bp.BtbHitF = 1'b1; bp.BtbTargetF = 32'h200;
        #1;
        chk("learned_pred", {31'd0, bp.PredTakenF}, 32'd1);
        chk("learned_npc",  bp.PredNPCF, 32'h200);
        @(negedge clk); idle_f();

        br("bad_target", 32'h100, 32'h200, 1'b1, 1'b1, 32'h300, 1'b1, 32'h300);
        br("not_taken",  32'h100, 32'h200, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104);
        br("good",       32'h100, 32'h200, 1'b1, 1'b1, 32'h200, 1'b0, 32'h200);
        chk("good_brcnt", bp.BrCount, 32'd4);
        chk("good_miss",  bp.MissCount, 32'd3);

        for (int i = 0; i < 5; i++)
            br("sat", 32'h108, 32'h400, (i > 0), 1'b1, 32'h400, (i == 0), 32'h400);
        br("sat_nt", 32'h108, 32'h400, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10c);
        bp.PCF = 32'h108; bp.BtbHitF = 1'b1; bp.BtbTargetF = 32'h400;
        #1 chk("sat_still_taken", {31'd0, bp.PredTakenF}, 32'd1);
        chk("sat_brcnt", bp.BrCount, 32'd10);
        chk("sat_miss",  bp.MissCount, 32'd5);
        @(negedge clk); idle_f();

        // E holds a valid record but the opcode is not a branch
        bp.OpE = 7'h33; bp.BranchE = 1'b1; bp.BrNPC = 32'h999; bp.PCE = 32'h108;
        #1;
        chk("nonbr_mis", {31'd0, bp.MispredictE}, 32'd0);
        chk("nonbr_cpc", bp.CorrectPCE, 32'd0);
        @(negedge clk); bp.OpE = 7'h0;
        chk("nonbr_brcnt", bp.BrCount, 32'd10);
        chk("nonbr_miss",  bp.MissCount, 32'd5);

        bp.PCF = 32'h10; bp.BtbHitF = 1'b1; bp.BtbTargetF = 32'h500;
        #1 chk("stall_pred_f", {31'd0, bp.PredTakenF}, 32'd0);
        @(negedge clk); idle_f();
        @(negedge clk);
        bp.StallD = 1'b1; bp.StallE = 1'b1;
        bp.PCE = 32'h10; bp.OpE = BR; bp.BranchE = 1'b1; bp.BrNPC = 32'h500;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_mis", {31'd0, bp.MispredictE}, 32'd0);
            chk("stall_cpc", bp.CorrectPCE, 32'd0);
            @(negedge clk);
        end
        bp.StallD = 1'b0; bp.StallE = 1'b0;
        sb.push_back('{mis: 1'b1, cpc: 32'h500});
        #1 sb_check("stall_release");
        @(negedge clk); bp.OpE = 7'h0;
        chk("stall_brcnt", bp.BrCount, 32'd11);
        chk("stall_miss",  bp.MissCount, 32'd6);
        br("stall_nt", 32'h10, 32'h500, 1'b1, 1'b0, 32'h0, 1'b1, 32'h14);
        bp.PCF = 32'h10; bp.BtbHitF = 1'b1; bp.BtbTargetF = 32'h500;
        #1 chk("stall_one_update", {31'd0, bp.PredTakenF}, 32'd0);
        @(negedge clk); idle_f();

        bp.PCF = 32'h100; bp.BtbHitF = 1'b1; bp.BtbTargetF = 32'h200;
        @(negedge clk); idle_f();
        @(negedge clk);
        bp.StallE = 1'b1; bp.FlushE = 1'b1;
        bp.PCE = 32'h100; bp.OpE = BR; bp.BranchE = 1'b0;
        #1 chk("flush_stall_mis", {31'd0, bp.MispredictE}, 32'd0);
        @(negedge clk); bp.StallE = 1'b0; bp.FlushE = 1'b0;
        #1;
        chk("flushed_mis", {31'd0, bp.MispredictE}, 32'd0);
        chk("flushed_cpc", bp.CorrectPCE, 32'd0);
        @(negedge clk); bp.OpE = 7'h0;
        chk("flush_brcnt", bp.BrCount, 32'd12);
        chk("flush_miss",  bp.MissCount, 32'd7);

        bp.PCF = 32'h100; bp.BtbHitF = 1'b1; bp.BtbTargetF = 32'h200;
        #1 chk("rst_mid_pred_f", {31'd0, bp.PredTakenF}, 32'd1);
        @(negedge clk); idle_f();
        @(negedge clk);
        bp.PCE = 32'h100; bp.OpE = BR; bp.BranchE = 1'b0;
        sb.push_back('{mis: 1'b1, cpc: 32'h104});
        #1 sb_check("rst_mid_pre");
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_mid_mis",   {31'd0, bp.MispredictE}, 32'd0);
        chk("rst_mid_cpc",   bp.CorrectPCE, 32'd0);
        chk("rst_mid_brcnt", bp.BrCount, 32'd0);
        chk("rst_mid_miss",  bp.MissCount, 32'd0);
        bp.OpE = 7'h0;
        bp.PCF = 32'h100; bp.BtbHitF = 1'b1; bp.BtbTargetF = 32'h200;
        #1 chk("rst_ctr_100", {31'd0, bp.PredTakenF}, 32'd0);
        bp.PCF = 32'h108;
        #1 chk("rst_ctr_108", {31'd0, bp.PredTakenF}, 32'd0);
        @(negedge clk); idle_f();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
